// File: rtl/ps2_gpi_source.sv
// ps2_gpi_source
//   Receives PS/2 keyboard frames and turns each good scan-code byte into
//   a one-cycle write strobe for CPU register R13 and flag F. Decoded bytes
//   wait in a small FIFO until the CPU clears its flag with gpi_ack.
//
// Parameters
//   FIFO_DEPTH      bytes buffered (power of two, 2..16)
//   TIMEOUT_CYCLES  clock cycles without a PS/2 falling edge before a partial
//                   frame is abandoned
//
// Ports
//   clock      in   sole clock, all logic on its rising edge
//   reset      in   asynchronous active-low reset
//   ps2_clk    in   raw keyboard clock, asynchronous
//   ps2_data   in   raw keyboard data, asynchronous
//   gpi_ack    in   CPU flag-clear strobe, one cycle
//   gpi        out  [7:0] scan-code byte presented to R13
//   gpi_we     out  one-cycle write strobe for R13 / F
//   overflow   out  sticky, a byte was dropped because the FIFO was full
//   frame_err  out  one-cycle pulse per discarded frame
//
// Build option
//   PS2_BREAK_FILTER_EN  when defined, the break prefix 8'hF0 and the byte
//                        after it are consumed instead of delivered.
//
// Receiver states
//   state  | meaning
//   IDLE   | waiting for a start bit (data 0 on a falling edge)
//   DATA   | shifting in 8 data bits, LSB first
//   PARITY | sampling the odd-parity bit
//   STOP   | checking the stop bit, accepting or discarding the byte

module ps2_gpi_source #(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       gpi_ack,
  output logic [7:0] gpi,
  output logic       gpi_we,
  output logic       overflow,
  output logic       frame_err
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] TMO_ONE  = TW'(1);
  localparam logic [PW:0]   PTR_ONE  = (PW + 1)'(1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

  // synchronizers; prev holds last cycle's synchronized clock for edge detect
  logic ps2_clk_meta_q, ps2_clk_sync_q, ps2_clk_prev_q;
  logic ps2_data_meta_q, ps2_data_sync_q;

  state_t          state_q, state_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [7:0]      shift_q, shift_d;
  logic            par_ok_q, par_ok_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic            frame_err_q, frame_err_d;

  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [PW:0]     wr_ptr_q, wr_ptr_d;
  logic [PW:0]     rd_ptr_q, rd_ptr_d;
  logic [7:0]      gpi_q, gpi_d;
  logic            gpi_we_q;
  logic            pending_q, pending_d;
  logic            overflow_q, overflow_d;

  logic fall, timeout, accept, push, push_ok, pop, empty, full;

  assign fall    = ps2_clk_prev_q & ~ps2_clk_sync_q;
  // down-counter reaches zero exactly TIMEOUT_CYCLES cycles after the last edge
  assign timeout = (state_q != IDLE) && !fall && (tmo_q == '0);

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    par_ok_d    = par_ok_q;
    frame_err_d = 1'b0;
    accept      = 1'b0;
    case (state_q)
      IDLE: begin
        if (fall && !ps2_data_sync_q) begin
          state_d   = DATA;
          bit_cnt_d = 3'd0;
        end
      end
      DATA: begin
        if (timeout) begin
          state_d     = IDLE;
          frame_err_d = 1'b1;
        end else if (fall) begin
          shift_d   = {ps2_data_sync_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = PARITY;
        end
      end
      PARITY: begin
        if (timeout) begin
          state_d     = IDLE;
          frame_err_d = 1'b1;
        end else if (fall) begin
          par_ok_d = ^{shift_q, ps2_data_sync_q};
          state_d  = STOP;
        end
      end
      STOP: begin
        if (timeout) begin
          state_d     = IDLE;
          frame_err_d = 1'b1;
        end else if (fall) begin
          if (ps2_data_sync_q && par_ok_q) accept = 1'b1;
          else frame_err_d = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    if (fall) tmo_d = TMO_LOAD;
    else if (state_q == IDLE || tmo_q == '0) tmo_d = '0;
    else tmo_d = tmo_q - TMO_ONE;
  end

`ifdef PS2_BREAK_FILTER_EN
  logic break_seen_q, break_seen_d;

  // F0 and the key code following it are swallowed; E0 is a normal byte here
  always_comb begin
    push         = 1'b0;
    break_seen_d = break_seen_q;
    if (accept) begin
      if (break_seen_q) break_seen_d = 1'b0;
      else if (shift_q == 8'hF0) break_seen_d = 1'b1;
      else push = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) break_seen_q <= 1'b0;
    else        break_seen_q <= break_seen_d;
  end
`else
  assign push = accept;
`endif

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                 (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);

  // an ack pops in the same cycle so gpi_we follows it directly; blocking on
  // gpi_we_q keeps strobes from landing on consecutive cycles
  assign pop     = !empty && !gpi_we_q && (!pending_q || gpi_ack);
  assign push_ok = push && (!full || pop);

  always_comb begin
    wr_ptr_d   = push_ok ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d   = pop ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    gpi_d      = pop ? mem_q[rd_ptr_q[PW-1:0]] : gpi_q;
    overflow_d = overflow_q | (push && !push_ok);
    if (pop)          pending_d = 1'b1;
    else if (gpi_ack) pending_d = 1'b0;
    else              pending_d = pending_q;
  end

  always_ff @(posedge clock) begin
    if (push_ok) mem_q[wr_ptr_q[PW-1:0]] <= shift_q;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ps2_clk_meta_q  <= 1'b1;
      ps2_clk_sync_q  <= 1'b1;
      ps2_clk_prev_q  <= 1'b1;
      ps2_data_meta_q <= 1'b1;
      ps2_data_sync_q <= 1'b1;
      state_q         <= IDLE;
      bit_cnt_q       <= 3'd0;
      shift_q         <= 8'h00;
      par_ok_q        <= 1'b0;
      tmo_q           <= '0;
      frame_err_q     <= 1'b0;
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      gpi_q           <= 8'h00;
      gpi_we_q        <= 1'b0;
      pending_q       <= 1'b0;
      overflow_q      <= 1'b0;
    end else begin
      ps2_clk_meta_q  <= ps2_clk;
      ps2_clk_sync_q  <= ps2_clk_meta_q;
      ps2_clk_prev_q  <= ps2_clk_sync_q;
      ps2_data_meta_q <= ps2_data;
      ps2_data_sync_q <= ps2_data_meta_q;
      state_q         <= state_d;
      bit_cnt_q       <= bit_cnt_d;
      shift_q         <= shift_d;
      par_ok_q        <= par_ok_d;
      tmo_q           <= tmo_d;
      frame_err_q     <= frame_err_d;
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      gpi_q           <= gpi_d;
      gpi_we_q        <= pop;
      pending_q       <= pending_d;
      overflow_q      <= overflow_d;
    end
  end

  assign gpi       = gpi_q;
  assign gpi_we    = gpi_we_q;
  assign overflow  = overflow_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_ps2_gpi_source.sv
module tb_ps2_gpi_source;

  localparam int HALF = 6;
  localparam int TMO  = 200;

  logic       clock = 1'b0;
  logic       rst_n = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       gpi_ack = 1'b0;
  logic [7:0] gpi;
  logic       gpi_we, overflow, frame_err;

  int n_cmp = 0;
  int n_err = 0;
  int we_cnt = 0;
  int ferr_cnt = 0;
  int consec = 0;
  logic [7:0] last_gpi = 8'h00;
  logic prev_we = 1'b0;

  ps2_gpi_source #(.FIFO_DEPTH(4), .TIMEOUT_CYCLES(TMO)) dut (
    .clock(clock), .reset(rst_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .gpi_ack(gpi_ack), .gpi(gpi), .gpi_we(gpi_we), .overflow(overflow),
    .frame_err(frame_err)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (gpi_we) begin
      we_cnt++;
      last_gpi = gpi;
      if (prev_we) consec++;
    end
    prev_we = gpi_we;
    if (frame_err) ferr_cnt++;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic ps2_bit(input logic b);
    ps2_data = b;
    cyc(HALF);
    ps2_clk = 1'b0;
    cyc(HALF);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic flip, input logic stop,
                            input logic ack_at_stop);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(d[i]);
    ps2_bit((~^d) ^ flip);
    ps2_data = stop;
    cyc(HALF);
    ps2_clk = 1'b0;
    if (ack_at_stop) begin
      // ack reaches the DUT in the very cycle the byte is pushed
      cyc(2);
      gpi_ack = 1'b1;
      cyc(1);
      gpi_ack = 1'b0;
      cyc(HALF - 3);
    end else begin
      cyc(HALF);
    end
    ps2_clk = 1'b1;
    cyc(HALF);
  endtask

  task automatic ack();
    gpi_ack = 1'b1;
    cyc(1);
    gpi_ack = 1'b0;
    cyc(3);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cyc(3);
    rst_n = 1'b1;
    cyc(2);
  endtask

  typedef struct {
    logic [7:0] data;
    logic       flip;
    logic       stop;
    int         exp_we;
    logic [7:0] exp_gpi;
    int         exp_ferr;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int w0, f0;
    logic [7:0] hold;
    logic [7:0] d;
    vecs[0] = '{8'h1C, 1'b0, 1'b1, 1, 8'h1C, 0};
    vecs[1] = '{8'h1C, 1'b1, 1'b1, 0, 8'h00, 1};
    vecs[2] = '{8'h23, 1'b0, 1'b1, 1, 8'h23, 0};
    vecs[3] = '{8'h5A, 1'b0, 1'b0, 0, 8'h00, 1};
    vecs[4] = '{8'h00, 1'b0, 1'b1, 1, 8'h00, 0};
    vecs[5] = '{8'hFF, 1'b0, 1'b1, 1, 8'hFF, 0};
    vecs[6] = '{8'hE0, 1'b0, 1'b1, 1, 8'hE0, 0};
    vecs[7] = '{8'h80, 1'b1, 1'b0, 0, 8'h00, 1};

    cyc(3);
    check("rst_gpi", gpi, 8'h00);
    check("rst_gpi_we", gpi_we, 0);
    check("rst_overflow", overflow, 0);
    check("rst_frame_err", frame_err, 0);
    rst_n = 1'b1;
    cyc(2);

    // single frame: exact strobe latency from the stop-bit edge
    f0 = ferr_cnt;
    d  = 8'h1C;
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(d[i]);
    ps2_bit(~^d);
    ps2_data = 1'b1;
    cyc(HALF);
    ps2_clk = 1'b0;
    repeat (3) @(posedge clock);
    #1 check("lat_we_early", gpi_we, 0);
    @(posedge clock);
    #1 check("lat_we", gpi_we, 1);
    check("lat_gpi", gpi, 8'h1C);
    @(posedge clock);
    #1 check("lat_we_single", gpi_we, 0);
    @(negedge clock);
    cyc(HALF);
    ps2_clk = 1'b1;
    cyc(HALF);
    check("lat_ferr", ferr_cnt - f0, 0);
    ack();
    hold = 8'h1C;

    // table of single frames, each acknowledged when delivered
    for (int k = 0; k < 8; k++) begin
      w0 = we_cnt;
      f0 = ferr_cnt;
      send_frame(vecs[k].data, vecs[k].flip, vecs[k].stop, 1'b0);
      cyc(5);
      check($sformatf("vec%0d_we", k), we_cnt - w0, vecs[k].exp_we);
      check($sformatf("vec%0d_ferr", k), ferr_cnt - f0, vecs[k].exp_ferr);
      if (vecs[k].exp_we != 0) hold = vecs[k].exp_gpi;
      check($sformatf("vec%0d_gpi", k), gpi, hold);
      if (vecs[k].exp_we != 0) ack();
    end

    // back-to-back frames, second one released by the ack
    w0 = we_cnt;
    send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
    send_frame(8'h32, 1'b0, 1'b1, 1'b0);
    cyc(5);
    check("b2b_we", we_cnt - w0, 1);
    check("b2b_first", last_gpi, 8'h1C);
    gpi_ack = 1'b1;
    @(posedge clock);
    #1 check("b2b_ack_we", gpi_we, 1);
    check("b2b_ack_gpi", gpi, 8'h32);
    @(negedge clock);
    gpi_ack = 1'b0;
    cyc(3);
    check("b2b_we_total", we_cnt - w0, 2);
    ack();

    // partial frame abandoned by timeout
    w0 = we_cnt;
    f0 = ferr_cnt;
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    cyc(TMO / 2);
    check("tmo_early", ferr_cnt - f0, 0);
    cyc(TMO);
    check("tmo_ferr", ferr_cnt - f0, 1);
    check("tmo_we", we_cnt - w0, 0);
    send_frame(8'h15, 1'b0, 1'b1, 1'b0);
    cyc(5);
    check("tmo_next_we", we_cnt - w0, 1);
    check("tmo_next_gpi", last_gpi, 8'h15);
    check("tmo_next_ferr", ferr_cnt - f0, 1);
    ack();

    // six frames with no ack: one delivered, four buffered, sixth dropped
    do_reset();
    w0 = we_cnt;
    for (int k = 1; k <= 5; k++) send_frame(8'(k), 1'b0, 1'b1, 1'b0);
    cyc(5);
    check("ovf_before", overflow, 0);
    send_frame(8'h06, 1'b0, 1'b1, 1'b0);
    cyc(5);
    check("ovf_set", overflow, 1);
    check("ovf_we", we_cnt - w0, 1);
    check("ovf_first", last_gpi, 8'h01);
    for (int k = 2; k <= 5; k++) begin
      ack();
      check($sformatf("ovf_drain%0d", k), last_gpi, 8'(k));
    end
    ack();
    check("ovf_drain_we", we_cnt - w0, 5);
    check("ovf_sticky", overflow, 1);

    // reset in the middle of a frame
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b1);
    rst_n = 1'b0;
    cyc(1);
    check("mid_rst_ovf", overflow, 0);
    check("mid_rst_gpi", gpi, 8'h00);
    cyc(2);
    rst_n = 1'b1;
    cyc(HALF);
    w0 = we_cnt;
    f0 = ferr_cnt;
    send_frame(8'h2A, 1'b0, 1'b1, 1'b0);
    cyc(5);
    check("mid_rst_we", we_cnt - w0, 1);
    check("mid_rst_data", last_gpi, 8'h2A);
    check("mid_rst_ferr", ferr_cnt - f0, 0);
    ack();

    // full FIFO with a pop in the push cycle still accepts the byte
    do_reset();
    for (int k = 1; k <= 5; k++) send_frame(8'(k), 1'b0, 1'b1, 1'b0);
    send_frame(8'h06, 1'b0, 1'b1, 1'b1);
    cyc(5);
    check("fullpop_ovf", overflow, 0);
    check("fullpop_gpi", last_gpi, 8'h02);
    for (int k = 3; k <= 6; k++) begin
      ack();
      check($sformatf("fullpop_drain%0d", k), last_gpi, 8'(k));
    end
    ack();

    // break prefix sequence
    do_reset();
    w0 = we_cnt;
`ifdef PS2_BREAK_FILTER_EN
    send_frame(8'hF0, 1'b0, 1'b1, 1'b0);
    send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
    send_frame(8'h32, 1'b0, 1'b1, 1'b0);
    cyc(5);
    check("brk_we", we_cnt - w0, 1);
    check("brk_gpi", last_gpi, 8'h32);
`else
    send_frame(8'hF0, 1'b0, 1'b1, 1'b0);
    cyc(5);
    check("brk_gpi0", last_gpi, 8'hF0);
    ack();
    send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
    cyc(5);
    check("brk_gpi1", last_gpi, 8'h1C);
    ack();
    send_frame(8'h32, 1'b0, 1'b1, 1'b0);
    cyc(5);
    check("brk_gpi2", last_gpi, 8'h32);
    check("brk_we", we_cnt - w0, 3);
`endif
    ack();

    check("we_consecutive", consec, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
